morse_encoder: RTL and testbench

- Converts one character code per handshake into an on/off Morse keying pattern on `led` using standard unit timing.
- Sits directly upstream of the board LED output stage and replaces the free-running blink pattern with character-driven keying.
- Characters arrive from the input/selection logic over a valid/ready handshake; the block holds `char_ready` low until the full letter, including the trailing gap, has been keyed out.

---
 rtl/morse_encoder.sv | 186 ++++++++++++++++++
 tb/tb_morse_encoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/morse_encoder.sv
// morse_encoder: keys one character code per valid/ready handshake onto
// `led` as standard Morse timing (dot 1U, dash 3U, element gap 1U,
// letter gap 3U, word space 7U).
// Optional feature macro: MORSE_DIGITS_EN. When it is defined, codes 26-35
// key the digits 0-9. Otherwise those codes take the error path.
module morse_encoder #(
  parameter int unsigned UNIT_CYCLES = 32'd12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       led,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    ESPACE,
    LGAP,
    WGAP,
    ERR
  } state_t;

  // Counter reload values: a state lasts n units and ends on the cycle the
  // counter reads zero, so each reload is n*UNIT_CYCLES-1.
  localparam logic [31:0] CNT1 = 32'(UNIT_CYCLES) - 32'd1;
  localparam logic [31:0] CNT3 = 32'(3 * UNIT_CYCLES) - 32'd1;
  localparam logic [31:0] CNT7 = 32'(7 * UNIT_CYCLES) - 32'd1;

  localparam logic [5:0] WORD_SPACE = 6'd63;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  pat_q, pat_d;
  logic [2:0]  len_q, len_d;
  logic        led_q;
  logic        err_q;

  logic [2:0]  romLen;
  logic [4:0]  romPat;
  logic        romValid;

  // Code ROM: element count plus a left-aligned pattern, first element in
  // bit 4, 1 = dash. A length of zero marks the code as not a character.
  always_comb begin
    {romLen, romPat} = 8'd0;
    case (char_in)
      6'd0:  {romLen, romPat} = {3'd2, 5'b01000}; // A .-
      6'd1:  {romLen, romPat} = {3'd4, 5'b10000}; // B -...
      6'd2:  {romLen, romPat} = {3'd4, 5'b10100}; // C -.-.
      6'd3:  {romLen, romPat} = {3'd3, 5'b10000}; // D -..
      6'd4:  {romLen, romPat} = {3'd1, 5'b00000}; // E .
      6'd5:  {romLen, romPat} = {3'd4, 5'b00100}; // F ..-.
      6'd6:  {romLen, romPat} = {3'd3, 5'b11000}; // G --.
      6'd7:  {romLen, romPat} = {3'd4, 5'b00000}; // H ....
      6'd8:  {romLen, romPat} = {3'd2, 5'b00000}; // I ..
      6'd9:  {romLen, romPat} = {3'd4, 5'b01110}; // J .---
      6'd10: {romLen, romPat} = {3'd3, 5'b10100}; // K -.-
      6'd11: {romLen, romPat} = {3'd4, 5'b01000}; // L .-..
      6'd12: {romLen, romPat} = {3'd2, 5'b11000}; // M --
      6'd13: {romLen, romPat} = {3'd2, 5'b10000}; // N -.
      6'd14: {romLen, romPat} = {3'd3, 5'b11100}; // O ---
      6'd15: {romLen, romPat} = {3'd4, 5'b01100}; // P .--.
      6'd16: {romLen, romPat} = {3'd4, 5'b11010}; // Q --.-
      6'd17: {romLen, romPat} = {3'd3, 5'b01000}; // R .-.
      6'd18: {romLen, romPat} = {3'd3, 5'b00000}; // S ...
      6'd19: {romLen, romPat} = {3'd1, 5'b10000}; // T -
      6'd20: {romLen, romPat} = {3'd3, 5'b00100}; // U ..-
      6'd21: {romLen, romPat} = {3'd4, 5'b00010}; // V ...-
      6'd22: {romLen, romPat} = {3'd3, 5'b01100}; // W .--
      6'd23: {romLen, romPat} = {3'd4, 5'b10010}; // X -..-
      6'd24: {romLen, romPat} = {3'd4, 5'b10110}; // Y -.--
      6'd25: {romLen, romPat} = {3'd4, 5'b11000}; // Z --..
`ifdef MORSE_DIGITS_EN
      6'd26: {romLen, romPat} = {3'd5, 5'b11111}; // 0 -----
      6'd27: {romLen, romPat} = {3'd5, 5'b01111}; // 1 .----
      6'd28: {romLen, romPat} = {3'd5, 5'b00111}; // 2 ..---
      6'd29: {romLen, romPat} = {3'd5, 5'b00011}; // 3 ...--
      6'd30: {romLen, romPat} = {3'd5, 5'b00001}; // 4 ....-
      6'd31: {romLen, romPat} = {3'd5, 5'b00000}; // 5 .....
      6'd32: {romLen, romPat} = {3'd5, 5'b10000}; // 6 -....
      6'd33: {romLen, romPat} = {3'd5, 5'b11000}; // 7 --...
      6'd34: {romLen, romPat} = {3'd5, 5'b11100}; // 8 ---..
      6'd35: {romLen, romPat} = {3'd5, 5'b11110}; // 9 ----.
`else
`endif
      default: {romLen, romPat} = 8'd0;
    endcase
    romValid = (romLen != 3'd0);
  end

  // Next-state logic: accept in IDLE, then walk the elements with one
  // shared down-counter. Only the not-yet-keyed pattern bits are kept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (char_valid) begin
          if (char_in == WORD_SPACE) begin
            state_d = WGAP;
            cnt_d   = CNT7;
          end else if (romValid) begin
            state_d = MARK;
            cnt_d   = romPat[4] ? CNT3 : CNT1;
            pat_d   = romPat[3:0];
            len_d   = romLen;
          end else begin
            state_d = ERR;
            cnt_d   = 32'd0;
          end
        end
      end
      MARK: begin
        if (cnt_q == 32'd0) begin
          if (len_q > 3'd1) begin
            state_d = ESPACE;
            cnt_d   = CNT1;
          end else begin
            state_d = LGAP;
            cnt_d   = CNT3;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ESPACE: begin
        if (cnt_q == 32'd0) begin
          state_d = MARK;
          cnt_d   = pat_q[3] ? CNT3 : CNT1;
          pat_d   = {pat_q[2:0], 1'b0};
          len_d   = len_q - 3'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      LGAP, WGAP: begin
        if (cnt_q == 32'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      ERR: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 32'd0;
      end
    endcase
  end

  // State, counter and registered outputs. led/err follow the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      pat_q   <= 4'd0;
      len_q   <= 3'd0;
      led_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      led_q   <= (state_d == MARK);
      err_q   <= (state_d == ERR);
    end
  end

  assign led        = led_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);
  assign char_ready = (state_q == IDLE);

endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: directed, table-driven checks of morse_encoder with
// UNIT_CYCLES = 4. Build with +define+MORSE_DIGITS_EN to cover digits.
module tb_morse_encoder;

  localparam int U = 4;

  logic       clk;
  logic       rstN;
  logic [5:0] charIn;
  logic       charValid;
  logic       charReady;
  logic       led;
  logic       busy;
  logic       err;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    string      name;
    logic [5:0] code;
    int         occ;
    int         marks;
    int         errs;
    int         firstLed;
  } vec_t;

  vec_t vecs[$];

  morse_encoder #(.UNIT_CYCLES(U)) dut (
    .clk        (clk),
    .rst_n      (rstN),
    .char_in    (charIn),
    .char_valid (charValid),
    .char_ready (charReady),
    .led        (led),
    .busy       (busy),
    .err        (err)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something upstream never returns.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Present one code while idle and drop valid right after the accepting edge.
  task automatic applyStimulus(input logic [5:0] code);
    @(negedge clk);
    charIn    = code;
    charValid = 1'b1;
    @(posedge clk);
    #1;
    charValid = 1'b0;
  endtask

  // Key one character and summarise what appeared on the outputs until
  // char_ready comes back (bounded at 200 cycles).
  task automatic runChar(input logic [5:0] code, output int occ, output int marks,
                         output int errs, output int firstLed, output int badBusy);
    occ = 0; marks = 0; errs = 0; firstLed = -1; badBusy = 0;
    applyStimulus(code);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (charReady === 1'b1) break;
      occ++;
      if (led === 1'b1) marks++;
      if (err === 1'b1) errs++;
      if (c == 1) firstLed = int'(led);
      if (busy !== 1'b1) badBusy++;
    end
  endtask

  initial begin
    int occ, marks, errs, firstLed, badBusy;
    int expLed, expReady;

    charIn    = 6'd0;
    charValid = 1'b0;
    rstN      = 1'b0;

    // Expected outcomes, hand computed for U = 4:
    // occupancy = marks + (elements-1)*U + 3U.
    vecs.push_back('{"E",      6'd4,  16,  4, 0, 1});
    vecs.push_back('{"T",      6'd19, 24, 12, 0, 1});
    vecs.push_back('{"A",      6'd0,  32, 16, 0, 1});
    vecs.push_back('{"S",      6'd18, 32, 12, 0, 1});
    vecs.push_back('{"O",      6'd14, 56, 36, 0, 1});
    vecs.push_back('{"Q",      6'd16, 64, 40, 0, 1});
    vecs.push_back('{"Y",      6'd24, 64, 40, 0, 1});
    vecs.push_back('{"Z",      6'd25, 56, 32, 0, 1});
    vecs.push_back('{"wspace", 6'd63, 28,  0, 0, 0});
    vecs.push_back('{"bad40",  6'd40,  1,  0, 1, 0});
    vecs.push_back('{"bad36",  6'd36,  1,  0, 1, 0});
    vecs.push_back('{"bad62",  6'd62,  1,  0, 1, 0});
`ifdef MORSE_DIGITS_EN
    vecs.push_back('{"dig0",   6'd26, 88, 60, 0, 1});
    vecs.push_back('{"dig9",   6'd35, 80, 52, 0, 1});
`else
    vecs.push_back('{"dig0",   6'd26,  1,  0, 1, 0});
    vecs.push_back('{"dig9",   6'd35,  1,  0, 1, 0});
`endif

    // Reset values while rst_n is held low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_led",   32'(led),       32'd0);
    checkOutput("reset_busy",  32'(busy),      32'd0);
    checkOutput("reset_err",   32'(err),       32'd0);
    checkOutput("reset_ready", 32'(charReady), 32'd1);
    rstN = 1'b1;

    // Table-driven characters.
    foreach (vecs[i]) begin
      runChar(vecs[i].code, occ, marks, errs, firstLed, badBusy);
      checkOutput({vecs[i].name, "_occ"},   32'(occ),      32'(vecs[i].occ));
      checkOutput({vecs[i].name, "_marks"}, 32'(marks),    32'(vecs[i].marks));
      checkOutput({vecs[i].name, "_errs"},  32'(errs),     32'(vecs[i].errs));
      checkOutput({vecs[i].name, "_led1"},  32'(firstLed), 32'(vecs[i].firstLed));
      checkOutput({vecs[i].name, "_busy"},  32'(badBusy),  32'd0);
    end

    // 'E' cycle by cycle: mark 1..4, gap 5..16, ready at 17.
    applyStimulus(6'd4);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      expLed   = (c <= 4) ? 1 : 0;
      expReady = (c == 17) ? 1 : 0;
      checkOutput($sformatf("E_led_c%0d", c),   32'(led),       32'(expLed));
      checkOutput($sformatf("E_ready_c%0d", c), 32'(charReady), 32'(expReady));
    end

    // 'A' then 'T' held valid; char_in changes while busy must be ignored.
    @(negedge clk);
    charIn    = 6'd0;
    charValid = 1'b1;
    @(posedge clk);
    #1;
    charIn = 6'd19;
    for (int c = 1; c <= 58; c++) begin
      @(negedge clk);
      expLed   = ((c >= 1 && c <= 4) || (c >= 9 && c <= 20) ||
                  (c >= 34 && c <= 45)) ? 1 : 0;
      expReady = (c == 33 || c == 58) ? 1 : 0;
      checkOutput($sformatf("AT_led_c%0d", c),   32'(led),       32'(expLed));
      checkOutput($sformatf("AT_ready_c%0d", c), 32'(charReady), 32'(expReady));
      if (c == 33) begin
        @(posedge clk);
        #1;
        charValid = 1'b0;
      end
    end

    // Reset during the second element (dash, cycles 9..20) of 'A'.
    applyStimulus(6'd0);
    for (int c = 1; c <= 10; c++) @(negedge clk);
    checkOutput("midA_led_before", 32'(led), 32'd1);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("midrst_led",   32'(led),       32'd0);
    checkOutput("midrst_busy",  32'(busy),      32'd0);
    checkOutput("midrst_ready", 32'(charReady), 32'd1);
    checkOutput("midrst_err",   32'(err),       32'd0);
    rstN = 1'b1;
    runChar(6'd4, occ, marks, errs, firstLed, badBusy);
    checkOutput("postrst_E_occ",   32'(occ),   32'd16);
    checkOutput("postrst_E_marks", 32'(marks), 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
